// File: rtl/pcw_loader_pkg.sv
// pcw_loader_pkg: shared state encoding and defaults for the PCW boot loader path
package pcw_loader_pkg;
  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] BOOT_ROM_END_D = 16'd275;
  localparam logic [ADDR_W-1:0] EXEC_ADDR_D = 16'h0000;
  localparam logic [7:0] HPS_INDEX_D = 8'd0;
  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_WR, S_EXEC, S_HPS} state_t;
endpackage

// File: rtl/edge_det.sv
// edge_det: falling-edge detector on a level input
module edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_fall
);
  logic r_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_prev <= 1'b0;
    else r_prev <= i_sig;
  assign o_fall = r_prev & ~i_sig;
endmodule

// File: rtl/pcw_boot_sequencer.sv
// pcw_boot_sequencer: copies boot ROM into core RAM and arbitrates the download port with HPS
module pcw_boot_sequencer
  import pcw_loader_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BOOT_ROM_END = BOOT_ROM_END_D,
  parameter logic [ADDR_W-1:0] EXEC_ADDR    = EXEC_ADDR_D,
  parameter logic [7:0]        HPS_INDEX    = HPS_INDEX_D
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              boot_start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [ADDR_W-1:0] ioctl_addr,
  input  logic [7:0]        ioctl_data,
  output logic              ioctl_wait,
  output logic              dn_go,
  output logic              dn_wr,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  input  logic              dn_wait,
  output logic [ADDR_W-1:0] execute_addr,
  output logic              execute_enable,
  output logic              busy
);
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt, r_dn_addr;
  logic [7:0]        r_dn_data;
  logic              r_pend;
  logic              w_fall, w_hps_req, w_can_preempt;
  edge_det u_edge (.clk(clk_sys), .rst_n(reset_n), .i_sig(boot_start), .o_fall(w_fall));
  assign w_hps_req      = ioctl_download && ioctl_index == HPS_INDEX;
  assign w_can_preempt  = r_state != S_HPS && r_state != S_EXEC;
  assign dn_wr          = !dn_wait && (r_state == S_WR || (r_state == S_HPS && r_pend));
  assign dn_go          = r_state inside {S_RD, S_LAT, S_WR, S_HPS};
  assign execute_enable = r_state == S_EXEC;
  assign busy           = r_state != S_IDLE;
  assign ioctl_wait     = r_pend;
  assign rom_addr       = r_cnt;
  assign dn_addr        = r_dn_addr;
  assign dn_data        = r_dn_data;
  assign execute_addr   = EXEC_ADDR;
  // HPS requests preempt a copy between writes; a write strobed this cycle still completes
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dn_addr <= '0;
      r_dn_data <= '0;
      r_pend    <= 1'b0;
    end else if (w_can_preempt && w_hps_req) begin
      r_state <= S_HPS;
    end else if (w_can_preempt && w_fall) begin
      r_cnt   <= '0;
      r_state <= S_RD;
    end else begin
      case (r_state)
        S_RD: r_state <= S_LAT;
        S_LAT: begin
          r_dn_addr <= r_cnt;
          r_dn_data <= rom_data;
          r_state   <= S_WR;
        end
        S_WR:
          if (!dn_wait) begin
            if (r_cnt == BOOT_ROM_END) r_state <= S_EXEC;
            else begin
              r_cnt   <= r_cnt + 1'b1;
              r_state <= S_RD;
            end
          end
        S_EXEC: r_state <= S_IDLE;
        S_HPS:
          if (ioctl_wr) begin
            r_dn_addr <= ioctl_addr;
            r_dn_data <= ioctl_data;
            r_pend    <= 1'b1;
          end else if (dn_wr) begin
            r_pend <= 1'b0;
          end else if (!ioctl_download && !r_pend) begin
            r_cnt   <= '0;
            r_state <= S_RD;
          end
        default: ;
      endcase
    end
endmodule
